// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run-control block: run states,
// default zone codes and the speed-level width helper.
package cpu_ctrl_pkg;

    // Run states; the encoding is visible on cpu_state.
    typedef enum logic [1:0] {
        ST_UI    = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_HALT  = 2'd3
    } run_state_t;

    // Default zone codes produced by the mouse zone selector.
    localparam int DEF_ZONE_SPEED = 1;
    localparam int DEF_ZONE_START = 5;
    localparam int DEF_ZONE_STEP  = 6;
    localparam int DEF_ZONE_RESET = 7;
    localparam int DEF_ZONE_STOP  = 8;

    // Width of the speed-level field; at least one bit.
    function automatic int speed_w(input int num_speeds);
        return (num_speeds > 2) ? $clog2(num_speeds) : 1;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Bundle of selector, CPU and breakpoint signals around cpu_run_ctrl.
// sel_valid qualifies sel_zone for exactly one cycle; there is no ready,
// every pulse is consumed in the cycle it is seen.
interface cpu_run_ctrl_if #(
    parameter int ZONE_W     = 6,
    parameter int PC_W       = 5,
    parameter int NUM_SPEEDS = 4
);
    import cpu_ctrl_pkg::*;

    localparam int SPD_W = speed_w(NUM_SPEEDS);

    logic              sel_valid;
    logic [ZONE_W-1:0] sel_zone;
    logic [PC_W-1:0]   pc;
    logic              cpu_error;
    logic              bp_en;
    logic [PC_W-1:0]   bp_addr;
    logic              cpu_tick;
    logic              cpu_run;
    logic              mem_reset;
    logic [1:0]        cpu_state;
    logic [SPD_W-1:0]  speed_lvl;
    logic              bp_hit;

    // Selector/CPU side: drives commands and CPU status, observes control.
    modport master (
        output sel_valid, sel_zone, pc, cpu_error, bp_en, bp_addr,
        input  cpu_tick, cpu_run, mem_reset, cpu_state, speed_lvl, bp_hit
    );

    // Run-control side.
    modport slave (
        input  sel_valid, sel_zone, pc, cpu_error, bp_en, bp_addr,
        output cpu_tick, cpu_run, mem_reset, cpu_state, speed_lvl, bp_hit
    );

endinterface

// File: rtl/cpu_run_ctrl_div.sv
// Execute-tick divider: period = BASE_PERIOD >> speed_lvl. Counts only
// while run is high; clr or a dropped run restarts the period from zero.
module tick_divider
    import cpu_ctrl_pkg::*;
#(
    parameter int BASE_PERIOD = 50000000,
    parameter int NUM_SPEEDS  = 4,
    localparam int SPD_W      = speed_w(NUM_SPEEDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             clr,
    input  logic [SPD_W-1:0] speed_lvl,
    output logic             tick
);
    localparam int CNT_W = $clog2(BASE_PERIOD);

    logic [CNT_W-1:0] count;
    logic [31:0]      period_m1;

    assign period_m1 = (32'(BASE_PERIOD) >> speed_lvl) - 32'd1;
    assign tick      = run && (32'(count) == period_m1);

    // Period counter: wraps on a tick, held at zero whenever not running.
    always_ff @(posedge clk) begin
        if (reset || clr || !run || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control engine: decodes zone-selection pulses into commands and
// sequences UI/RUN/PAUSE/HALT, with breakpoint, error halt and stepping.
// Event priority within a cycle: reset > cpu_error > breakpoint > command.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int ZONE_W      = 6,
    parameter int PC_W        = 5,
    parameter int NUM_SPEEDS  = 4,
    parameter int BASE_PERIOD = 50000000,
    parameter int ZONE_SPEED  = DEF_ZONE_SPEED,
    parameter int ZONE_START  = DEF_ZONE_START,
    parameter int ZONE_STEP   = DEF_ZONE_STEP,
    parameter int ZONE_RESET  = DEF_ZONE_RESET,
    parameter int ZONE_STOP   = DEF_ZONE_STOP
) (
    input logic           clk,
    input logic           reset,
    cpu_run_ctrl_if.slave bus
);
    localparam int SPD_W = speed_w(NUM_SPEEDS);

    run_state_t       state;
    logic [SPD_W-1:0] speed_lvl;
    logic             bp_hit;
    logic             bp_armed;
    logic             cpu_tick;
    logic             mem_reset;

    logic cmd_start, cmd_stop, cmd_step, cmd_reset, cmd_speed;
    logic in_run, err_halt, pc_at_bp, bp_trig, go_ui, stay_run;
    logic div_clr, div_tick;

    assign cmd_start = bus.sel_valid && (bus.sel_zone == ZONE_W'(ZONE_START));
    assign cmd_stop  = bus.sel_valid && (bus.sel_zone == ZONE_W'(ZONE_STOP));
    assign cmd_step  = bus.sel_valid && (bus.sel_zone == ZONE_W'(ZONE_STEP));
    assign cmd_reset = bus.sel_valid && (bus.sel_zone == ZONE_W'(ZONE_RESET));
    assign cmd_speed = bus.sel_valid && (bus.sel_zone == ZONE_W'(ZONE_SPEED));

    assign in_run   = (state == ST_RUN);
    assign err_halt = bus.cpu_error && (in_run || state == ST_PAUSE);
    assign pc_at_bp = (PC_W'(bus.pc) == PC_W'(bus.bp_addr));
    assign bp_trig  = in_run && bus.bp_en && bp_armed && pc_at_bp;
    // RESET from any non-UI state, unless an error or breakpoint wins.
    assign go_ui    = cmd_reset && (state != ST_UI) && !err_halt && !bp_trig;
    // Still in RUN after this edge: only then may a divider tick go out.
    assign stay_run = in_run && !err_halt && !bp_trig && !cmd_stop && !go_ui;
    assign div_clr  = stay_run && cmd_speed;

    tick_divider #(
        .BASE_PERIOD (BASE_PERIOD),
        .NUM_SPEEDS  (NUM_SPEEDS)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .run       (stay_run),
        .clr       (div_clr),
        .speed_lvl (speed_lvl),
        .tick      (div_tick)
    );

    // Run-state machine with registered control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_UI;
            speed_lvl <= '0;
            bp_hit    <= 1'b0;
            bp_armed  <= 1'b1;
            cpu_tick  <= 1'b0;
            mem_reset <= 1'b0;
        end else begin
            cpu_tick  <= 1'b0;
            mem_reset <= 1'b0;
            if (!pc_at_bp) begin
                bp_armed <= 1'b1;
            end
            if (go_ui) begin
                state     <= ST_UI;
                mem_reset <= 1'b1;
                speed_lvl <= '0;
                bp_hit    <= 1'b0;
            end else begin
                case (state)
                    ST_UI: begin
                        if (cmd_start) state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (err_halt) begin
                            state <= ST_HALT;
                        end else if (bp_trig) begin
                            state    <= ST_PAUSE;
                            bp_hit   <= 1'b1;
                            bp_armed <= 1'b0;
                        end else if (cmd_stop) begin
                            state     <= ST_PAUSE;
                            speed_lvl <= '0;
                        end else begin
                            cpu_tick <= div_tick;
                            if (cmd_speed) speed_lvl <= speed_lvl + SPD_W'(1);
                        end
                    end
                    ST_PAUSE: begin
                        if (err_halt) begin
                            state <= ST_HALT;
                        end else if (cmd_start) begin
                            state  <= ST_RUN;
                            bp_hit <= 1'b0;
                        end else if (cmd_step) begin
                            cpu_tick <= 1'b1;
                        end else if (cmd_speed) begin
                            speed_lvl <= speed_lvl + SPD_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.cpu_tick  = cpu_tick;
    assign bus.cpu_run   = in_run;
    assign bus.mem_reset = mem_reset;
    assign bus.cpu_state = state;
    assign bus.speed_lvl = speed_lvl;
    assign bus.bp_hit    = bp_hit;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios with literal expectations,
// then random traffic, all checked every cycle against a behavioural model.
module tb_cpu_run_ctrl;
    localparam int ZONE_W = 6, PC_W = 5, NUM_SPEEDS = 4, BASE_PERIOD = 8;
    localparam int Z_SPEED = 1, Z_START = 5, Z_STEP = 6, Z_RESET = 7, Z_STOP = 8;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    cpu_run_ctrl_if #(.ZONE_W(ZONE_W), .PC_W(PC_W), .NUM_SPEEDS(NUM_SPEEDS)) bus ();

    cpu_run_ctrl #(
        .ZONE_W(ZONE_W), .PC_W(PC_W), .NUM_SPEEDS(NUM_SPEEDS), .BASE_PERIOD(BASE_PERIOD),
        .ZONE_SPEED(Z_SPEED), .ZONE_START(Z_START), .ZONE_STEP(Z_STEP),
        .ZONE_RESET(Z_RESET), .ZONE_STOP(Z_STOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=UI 1=RUN 2=PAUSE 3=HALT. Divider ticks are
    // derived from the elapsed edges since the period origin (RUN entry or
    // last speed change), using modulo arithmetic.
    int m_mode = 0, m_speed = 0, m_origin = 0, edge_n = 0;
    bit m_bp_hit = 0, m_armed = 1, m_tick = 0, m_memr = 0, m_valid = 0;

    // Model update on each active edge from the inputs stable at that edge.
    always @(posedge clk) begin : model
        int per, z;
        bit hit, err, due;
        edge_n++;
        if (reset) begin
            m_mode = 0; m_speed = 0; m_bp_hit = 0; m_armed = 1;
            m_tick = 0; m_memr = 0; m_valid = 1;
        end else begin
            per = BASE_PERIOD >> m_speed;
            z   = bus.sel_valid ? int'(bus.sel_zone) : -1;
            hit = (m_mode == 1) && bus.bp_en && m_armed && (bus.pc == bus.bp_addr);
            err = bus.cpu_error && (m_mode == 1 || m_mode == 2);
            due = (m_mode == 1) && (((edge_n - m_origin) % per) == 0);
            m_tick = 0;
            m_memr = 0;
            if (bus.pc != bus.bp_addr) m_armed = 1;
            if (err) begin
                m_mode = 3;
            end else if (hit) begin
                m_mode = 2; m_bp_hit = 1; m_armed = 0;
            end else if (z == Z_RESET && m_mode != 0) begin
                m_mode = 0; m_memr = 1; m_speed = 0; m_bp_hit = 0;
            end else begin
                case (m_mode)
                    0: if (z == Z_START) begin m_mode = 1; m_origin = edge_n; end
                    1: begin
                        if (z == Z_STOP) begin
                            m_mode = 2; m_speed = 0;
                        end else begin
                            m_tick = due;
                            if (z == Z_SPEED) begin
                                m_speed = (m_speed + 1) % NUM_SPEEDS;
                                m_origin = edge_n;
                            end
                        end
                    end
                    2: begin
                        if (z == Z_START) begin
                            m_mode = 1; m_bp_hit = 0; m_origin = edge_n;
                        end else if (z == Z_STEP) begin
                            m_tick = 1;
                        end else if (z == Z_SPEED) begin
                            m_speed = (m_speed + 1) % NUM_SPEEDS;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Compare every DUT output against the model away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cpu_state", 32'(bus.cpu_state), m_mode);
            chk("cpu_run", 32'(bus.cpu_run), (m_mode == 1) ? 1 : 0);
            chk("cpu_tick", 32'(bus.cpu_tick), 32'(m_tick));
            chk("mem_reset", 32'(bus.mem_reset), 32'(m_memr));
            chk("speed_lvl", 32'(bus.speed_lvl), m_speed);
            chk("bp_hit", 32'(bus.bp_hit), 32'(m_bp_hit));
        end
    end

    // Driver tasks: all called at a falling edge, return at a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cmd(input int z);
        bus.sel_valid = 1'b1;
        bus.sel_zone  = ZONE_W'(z);
        @(negedge clk);
        bus.sel_valid = 1'b0;
        bus.sel_zone  = '0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_state"}, 32'(bus.cpu_state), 0);
        chk({name, "_tick"}, 32'(bus.cpu_tick), 0);
        chk({name, "_run"}, 32'(bus.cpu_run), 0);
        chk({name, "_memr"}, 32'(bus.mem_reset), 0);
        chk({name, "_speed"}, 32'(bus.speed_lvl), 0);
        chk({name, "_bphit"}, 32'(bus.bp_hit), 0);
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int zones[8] = '{1, 5, 6, 7, 8, 0, 3, 63};

    // Stimulus
    initial begin
        int n;
        reset = 1'b1;
        bus.sel_valid = 1'b0; bus.sel_zone = '0; bus.pc = '0;
        bus.cpu_error = 1'b0; bus.bp_en = 1'b0; bus.bp_addr = '0;
        idle(3);
        chk_all_zero("reset");
        reset = 1'b0;
        idle(2);
        chk("reset_release_memr", 32'(bus.mem_reset), 0);

        // 1: run and stop
        cmd(Z_START);
        chk("t1_state", 32'(bus.cpu_state), 1);
        chk("t1_run", 32'(bus.cpu_run), 1);
        for (int i = 1; i <= 32; i++) begin
            idle(1);
            chk("t1_tick", 32'(bus.cpu_tick), (i % 8 == 0) ? 1 : 0);
        end
        cmd(Z_STOP);
        chk("t1_stop_state", 32'(bus.cpu_state), 2);
        chk("t1_stop_speed", 32'(bus.speed_lvl), 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin idle(1); n += int'(bus.cpu_tick); end
        chk("t1_no_tick", n, 0);

        // 2: speed up and wrap
        cmd(Z_START);
        cmd(Z_SPEED); cmd(Z_SPEED); cmd(Z_SPEED);
        chk("t2_speed3", 32'(bus.speed_lvl), 3);
        for (int i = 0; i < 6; i++) begin
            idle(1);
            chk("t2_tick_l3", 32'(bus.cpu_tick), 1);
        end
        cmd(Z_SPEED);
        chk("t2_wrap", 32'(bus.speed_lvl), 0);
        for (int i = 1; i <= 8; i++) begin
            idle(1);
            chk("t2_tick_l0", 32'(bus.cpu_tick), (i == 8) ? 1 : 0);
        end

        // 3: single stepping
        cmd(Z_STOP); cmd(Z_SPEED); cmd(Z_SPEED);
        chk("t3_state", 32'(bus.cpu_state), 2);
        chk("t3_speed2", 32'(bus.speed_lvl), 2);
        n = 0;
        cmd(Z_STEP);
        n += int'(bus.cpu_tick);
        chk("t3_step1", 32'(bus.cpu_tick), 1);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            n += int'(bus.cpu_tick);
            chk("t3_gap", 32'(bus.cpu_tick), 0);
        end
        cmd(Z_STEP);
        n += int'(bus.cpu_tick);
        chk("t3_step2", 32'(bus.cpu_tick), 1);
        idle(1);
        n += int'(bus.cpu_tick);
        chk("t3_total", n, 2);
        cmd(Z_START);
        cmd(Z_STEP);
        chk("t3_step_in_run", 32'(bus.cpu_tick), 0);
        chk("t3_run_state", 32'(bus.cpu_state), 1);
        cmd(Z_RESET);
        chk("t3_ui", 32'(bus.cpu_state), 0);
        chk("t3_memr", 32'(bus.mem_reset), 1);
        chk("t3_memr_speed", 32'(bus.speed_lvl), 0);
        idle(1);
        chk("t3_memr_end", 32'(bus.mem_reset), 0);
        cmd(Z_STEP);
        chk("t3_step_in_ui", 32'(bus.cpu_tick), 0);

        // 4: breakpoint and resume
        bus.bp_en = 1'b1; bus.bp_addr = 5'd5; bus.pc = 5'd3;
        cmd(Z_START);
        bus.pc = 5'd4; idle(1);
        bus.pc = 5'd5; idle(1);
        chk("t4_bp_state", 32'(bus.cpu_state), 2);
        chk("t4_bp_hit", 32'(bus.bp_hit), 1);
        chk("t4_bp_tick", 32'(bus.cpu_tick), 0);
        idle(3);
        chk("t4_hold", 32'(bus.cpu_state), 2);
        cmd(Z_START);
        chk("t4_resume", 32'(bus.cpu_state), 1);
        chk("t4_hit_clr", 32'(bus.bp_hit), 0);
        idle(2);
        chk("t4_no_rebreak", 32'(bus.cpu_state), 1);
        bus.pc = 5'd6; idle(1);
        bus.pc = 5'd5; idle(1);
        chk("t4_rebreak", 32'(bus.cpu_state), 2);
        chk("t4_rehit", 32'(bus.bp_hit), 1);
        cmd(Z_STEP);
        chk("t4_step_past", 32'(bus.cpu_tick), 1);

        // 5: error halt and recovery
        bus.bp_en = 1'b0; bus.pc = '0;
        cmd(Z_START);
        cmd(Z_SPEED);
        chk("t5_speed1", 32'(bus.speed_lvl), 1);
        bus.cpu_error = 1'b1;
        cmd(Z_STOP);
        bus.cpu_error = 1'b0;
        chk("t5_halt", 32'(bus.cpu_state), 3);
        cmd(Z_START);
        chk("t5_start_ignored", 32'(bus.cpu_state), 3);
        cmd(Z_RESET);
        chk("t5_ui", 32'(bus.cpu_state), 0);
        chk("t5_memr", 32'(bus.mem_reset), 1);
        chk("t5_speed0", 32'(bus.speed_lvl), 0);
        idle(1);
        chk("t5_memr_end", 32'(bus.mem_reset), 0);

        // 6: reset mid-run with SPEED and a due tick
        cmd(Z_START);
        idle(7);
        reset = 1'b1;
        bus.sel_valid = 1'b1; bus.sel_zone = ZONE_W'(Z_SPEED);
        idle(1);
        bus.sel_valid = 1'b0; bus.sel_zone = '0;
        chk_all_zero("t6");
        reset = 1'b0;
        idle(1);
        chk("t6_no_memr", 32'(bus.mem_reset), 0);

        // Random traffic
        bus.bp_addr = 5'd9;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 1) == 0) bus.pc = PC_W'($urandom_range(7, 12));
            bus.bp_en     = ($urandom_range(0, 3) != 0);
            bus.cpu_error = ($urandom_range(0, 99) == 0);
            reset         = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.sel_valid = 1'b1;
                bus.sel_zone  = ZONE_W'(zones[$urandom_range(0, 7)]);
            end else begin
                bus.sel_valid = 1'b0;
                bus.sel_zone  = '0;
            end
            idle(1);
        end
        reset = 1'b0; bus.sel_valid = 1'b0; bus.cpu_error = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
